// File: rtl/vga_pkg.sv
// Shared raster timing defaults and helpers for the VGA timing engine.
// Default values describe standard 640x480 @ 60 Hz timing with a 25 MHz pixel rate.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 11;
  localparam int DEF_COLOR_W  = 4;

  // Works for either axis: H_TOTAL and V_TOTAL are both active + porches + sync.
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// Pixel request and VGA pin bundle between the timing engine, pixel source and board pins.
// The master side is the engine; the slave side supplies enable and pixel data.
interface vga_timing_engine_if
  import vga_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int COLOR_W = DEF_COLOR_W
);
  logic                   enable;
  logic [CNT_W-1:0]       req_x;
  logic [CNT_W-1:0]       req_y;
  logic                   req_de;
  logic [3*COLOR_W-1:0]   pix_in;
  logic                   pix_tick;
  logic                   frame_start;
  logic                   HSYNC;
  logic                   VSYNC;
  logic [COLOR_W-1:0]     Red;
  logic [COLOR_W-1:0]     Green;
  logic [COLOR_W-1:0]     Blue;

  modport master (
    input  enable, pix_in,
    output req_x, req_y, req_de, pix_tick, frame_start, HSYNC, VSYNC, Red, Green, Blue
  );

  modport slave (
    output enable, pix_in,
    input  req_x, req_y, req_de, pix_tick, frame_start, HSYNC, VSYNC, Red, Green, Blue
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with terminal-count, active and sync window decode.
// Decode is combinational from the count; clr returns the axis to the origin on the next edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // One extra bit so a sync window ending exactly at 2**CNT_W still decodes correctly.
  localparam logic [CNT_W:0] LAST      = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] ACT_END   = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] SYNC_BEG  = (CNT_W+1)'(ACTIVE + FP);
  localparam logic [CNT_W:0] SYNC_END  = (CNT_W+1)'(ACTIVE + FP + SYNC);

  logic [CNT_W:0] cnt_x;
  assign cnt_x = {1'b0, cnt};

  assign tc     = (cnt_x == LAST);
  assign active = (cnt_x < ACT_END);
  assign sync   = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster engine: divides clk_100mhz to pixel ticks, issues (x,y) requests, drives sync/RGB pins.
// Latency request -> pins is one pixel tick; no backpressure, the pixel source must keep pace.
module vga_timing_engine
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = DEF_CNT_W,
  parameter int   COLOR_W   = DEF_COLOR_W
) (
  input  logic                clk_100mhz,
  input  logic                RSTN,
  vga_timing_engine_if.master vga
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div;
  logic               tick;
  logic [CNT_W-1:0]   hcnt, vcnt;
  logic               h_tc, h_act, h_sync;
  logic               v_tc, v_act, v_sync;
  logic               at_origin;
  logic               hs1, vs1;
  logic [CNT_W-1:0]   req_x_q, req_y_q;
  logic               req_de_q, pix_tick_q, frame_start_q, hsync_q, vsync_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  // A low enable suppresses the tick even when the divider is at its last count.
  assign tick = vga.enable && (div == DIV_LAST);

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      div <= '0;
    end else if (!vga.enable || tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .CNT_W (CNT_W)
  ) u_hcnt (
    .clk (clk_100mhz), .rst_n (RSTN), .clr (!vga.enable), .adv (tick),
    .cnt (hcnt), .tc (h_tc), .active (h_act), .sync (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .CNT_W (CNT_W)
  ) u_vcnt (
    .clk (clk_100mhz), .rst_n (RSTN), .clr (!vga.enable), .adv (tick && h_tc),
    .cnt (vcnt), .tc (v_tc), .active (v_act), .sync (v_sync)
  );

  // at_origin tracks "next request is (0,0)" so frame_start needs no wide compare.
  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      at_origin     <= 1'b1;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      req_de_q      <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
    end else if (!vga.enable) begin
      at_origin     <= 1'b1;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      req_de_q      <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
    end else begin
      pix_tick_q    <= tick;
      frame_start_q <= tick && at_origin;
      if (tick) begin
        at_origin <= h_tc && v_tc;
        req_x_q   <= hcnt;
        req_y_q   <= vcnt;
        req_de_q  <= h_act && v_act;
        hs1       <= h_sync;
        vs1       <= v_sync;
        // Stage 2 consumes the request registered on the previous tick.
        red_q     <= req_de_q ? vga.pix_in[3*COLOR_W-1 -: COLOR_W] : '0;
        green_q   <= req_de_q ? vga.pix_in[2*COLOR_W-1 -: COLOR_W] : '0;
        blue_q    <= req_de_q ? vga.pix_in[COLOR_W-1 -: COLOR_W]   : '0;
        hsync_q   <= hs1 ? HSYNC_POL : ~HSYNC_POL;
        vsync_q   <= vs1 ? VSYNC_POL : ~VSYNC_POL;
      end
    end
  end

  assign vga.req_x       = req_x_q;
  assign vga.req_y       = req_y_q;
  assign vga.req_de      = req_de_q;
  assign vga.pix_tick    = pix_tick_q;
  assign vga.frame_start = frame_start_q;
  assign vga.HSYNC       = hsync_q;
  assign vga.VSYNC       = vsync_q;
  assign vga.Red         = red_q;
  assign vga.Green       = green_q;
  assign vga.Blue        = blue_q;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench: default 640x480 engine over two-plus lines, enable/reset control, and a tiny raster.
// Expected values are hand-derived from the raster timing; pins are sampled on the falling edge.
module tb_vga_timing_engine;

  logic clk_100mhz = 1'b0;
  logic RSTN;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  vga_timing_engine_if #(.CNT_W(11), .COLOR_W(4)) ifa ();
  vga_timing_engine_if #(.CNT_W(4),  .COLOR_W(4)) ifb ();

  vga_timing_engine #(
    .CLK_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(11), .COLOR_W(4)
  ) u_dut_a (.clk_100mhz(clk_100mhz), .RSTN(RSTN), .vga(ifa));

  vga_timing_engine #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(4), .COLOR_W(4)
  ) u_dut_b (.clk_100mhz(clk_100mhz), .RSTN(RSTN), .vga(ifb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns falling edges elapsed until pix_tick is seen; 8 means it never came.
  task automatic wait_tick_a(output int gap);
    gap = 0;
    do begin
      @(negedge clk_100mhz);
      gap++;
    end while (!ifa.pix_tick && gap < 8);
  endtask

  initial begin
    int gap, ex, ey, prev_x, prev_y;
    int req_err, pipe_err, gap_err, hs_low0, fff0, zero0, hs0_x, hs0_cyc, hs1_cyc;
    int b_notick, fs_first, fs_second, hs_hi, vs_lo, de_cnt;
    logic prev_de, exp_de, exp_hs, exp_vs, hs_at11, hs_at12;
    logic [11:0] prev_pix, exp_rgb, rgb;
    logic [3:0]  nib;
    logic [3:0]  b_end_x, b_end_y;

    RSTN = 1'b1;
    ifa.enable = 1'b1;
    ifa.pix_in = 12'h000;
    ifb.enable = 1'b0;
    ifb.pix_in = 12'hFFF;

    // Reset must take effect without any clock edge.
    #2 RSTN = 1'b0;
    #1;
    check("rst_req_x",    ifa.req_x, 0);
    check("rst_req_y",    ifa.req_y, 0);
    check("rst_req_de",   ifa.req_de, 0);
    check("rst_pix_tick", ifa.pix_tick, 0);
    check("rst_fs",       ifa.frame_start, 0);
    check("rst_hsync",    ifa.HSYNC, 1);
    check("rst_vsync",    ifa.VSYNC, 1);
    check("rst_rgb",      {ifa.Red, ifa.Green, ifa.Blue}, 0);
    check("rst_b_hsync",  ifb.HSYNC, 0);
    check("rst_b_vsync",  ifb.VSYNC, 1);

    repeat (3) @(negedge clk_100mhz);
    RSTN = 1'b1;

    wait_tick_a(gap);
    check("first_gap",   gap, 4);
    check("first_x",     ifa.req_x, 0);
    check("first_y",     ifa.req_y, 0);
    check("first_de",    ifa.req_de, 1);
    check("first_fs",    ifa.frame_start, 1);
    check("first_hsync", ifa.HSYNC, 1);
    check("first_vsync", ifa.VSYNC, 1);

    // Observation n shows request n; the pins show request n-1.
    ex = 0; ey = 0; prev_x = 0; prev_y = 0; prev_de = 1'b0; prev_pix = 12'h000;
    req_err = 0; pipe_err = 0; gap_err = 0; hs_low0 = 0; fff0 = 0; zero0 = 0;
    hs0_x = -1; hs0_cyc = -1; hs1_cyc = -1;
    for (int n = 0; n < 1901; n++) begin
      if (n > 0) begin
        wait_tick_a(gap);
        if (gap != 4) gap_err++;
      end
      exp_de = (ex < 640) && (ey < 480);
      if (ifa.req_x !== 11'(ex) || ifa.req_y !== 11'(ey) || ifa.req_de !== exp_de ||
          ifa.frame_start !== (ex == 0 && ey == 0)) req_err++;
      exp_rgb = prev_de ? prev_pix : 12'h000;
      exp_hs  = !(prev_x >= 656 && prev_x < 752);
      exp_vs  = !(prev_y >= 490 && prev_y < 492);
      rgb     = {ifa.Red, ifa.Green, ifa.Blue};
      if (rgb !== exp_rgb || ifa.HSYNC !== exp_hs || ifa.VSYNC !== exp_vs) pipe_err++;
      if (n > 0 && prev_y == 0) begin
        if (!ifa.HSYNC) hs_low0++;
        if (rgb == 12'hFFF) fff0++;
        if (rgb == 12'h000) zero0++;
        if (!ifa.HSYNC && hs0_x < 0) begin
          hs0_x   = int'(ifa.req_x);
          hs0_cyc = cyc;
        end
      end
      if (prev_y == 1 && !ifa.HSYNC && hs1_cyc < 0) hs1_cyc = cyc;
      prev_x  = ex;
      prev_y  = ey;
      prev_de = exp_de;
      nib = 4'(ex);
      ifa.pix_in = (ey == 0) ? 12'hFFF : {nib, nib, nib};
      prev_pix = ifa.pix_in;
      ex++;
      if (ex == 800) begin
        ex = 0;
        ey++;
      end
    end
    check("req_sequence",  req_err, 0);
    check("pipe_latency",  pipe_err, 0);
    check("tick_gap",      gap_err, 0);
    check("hs_low_line0",  hs_low0, 96);
    check("rgb_fff_line0", fff0, 640);
    check("rgb_zero_line0", zero0, 160);
    check("hs_first_x",    hs0_x, 657);
    check("hs_period_clk", hs1_cyc - hs0_cyc, 3200);
    check("stop_x",        ifa.req_x, 300);
    check("stop_y",        ifa.req_y, 2);

    // Drop enable on the cycle the divider would tick: enable must win.
    repeat (3) @(negedge clk_100mhz);
    check("hold_x", ifa.req_x, 300);
    ifa.enable = 1'b0;
    @(negedge clk_100mhz);
    check("dis_pix_tick", ifa.pix_tick, 0);
    check("dis_req_x",    ifa.req_x, 0);
    check("dis_req_y",    ifa.req_y, 0);
    check("dis_req_de",   ifa.req_de, 0);
    check("dis_hsync",    ifa.HSYNC, 1);
    check("dis_vsync",    ifa.VSYNC, 1);
    check("dis_rgb",      {ifa.Red, ifa.Green, ifa.Blue}, 0);

    ifa.pix_in = 12'hFFF;
    ifa.enable = 1'b1;
    wait_tick_a(gap);
    check("re_gap", gap, 4);
    check("re_x",   ifa.req_x, 0);
    check("re_y",   ifa.req_y, 0);
    check("re_fs",  ifa.frame_start, 1);

    for (int i = 0; i < 20; i++) wait_tick_a(gap);
    check("pre_rst_x",   ifa.req_x, 20);
    check("pre_rst_rgb", {ifa.Red, ifa.Green, ifa.Blue}, 12'hFFF);
    #1 RSTN = 1'b0;
    #1;
    check("mid_rst_x",     ifa.req_x, 0);
    check("mid_rst_tick",  ifa.pix_tick, 0);
    check("mid_rst_rgb",   {ifa.Red, ifa.Green, ifa.Blue}, 0);
    check("mid_rst_hsync", ifa.HSYNC, 1);
    @(negedge clk_100mhz);
    RSTN = 1'b1;
    wait_tick_a(gap);
    check("post_rst_gap", gap, 4);
    check("post_rst_x",   ifa.req_x, 0);
    check("post_rst_fs",  ifa.frame_start, 1);

    // Tiny raster: 14-clock lines, 7 lines, 98-clock frames, active-high HSYNC.
    b_notick = 0; fs_first = -1; fs_second = -1; hs_hi = 0; vs_lo = 0; de_cnt = 0;
    hs_at11 = 1'bx; hs_at12 = 1'bx; b_end_x = '0; b_end_y = '0;
    ifb.enable = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_100mhz);
      if (!ifb.pix_tick) b_notick++;
      if (ifb.frame_start) begin
        if (fs_first < 0) fs_first = c;
        else if (fs_second < 0) fs_second = c;
      end
      if (c >= 2 && c <= 99) begin
        if (ifb.HSYNC) hs_hi++;
        if (!ifb.VSYNC) vs_lo++;
        if ({ifb.Red, ifb.Green, ifb.Blue} == 12'hFFF) de_cnt++;
      end
      if (c == 11) hs_at11 = ifb.HSYNC;
      if (c == 12) hs_at12 = ifb.HSYNC;
      if (c == 200) begin
        b_end_x = ifb.req_x;
        b_end_y = ifb.req_y;
      end
    end
    check("b_no_tick",      b_notick, 0);
    check("b_fs_first",     fs_first, 1);
    check("b_frame_clks",   fs_second - fs_first, 98);
    check("b_hs_high",      hs_hi, 14);
    check("b_vs_low",       vs_lo, 14);
    check("b_rgb_active",   de_cnt, 32);
    check("b_hs_before",    hs_at11, 0);
    check("b_hs_start",     hs_at12, 1);
    check("b_end_x",        b_end_x, 3);
    check("b_end_y",        b_end_y, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
